// File: rtl/spi_transaction_fsm.sv
// SPI slave transaction sequencer: address byte, R/W decode, read load/shift or write shift/commit.
// Optional SPI_FSM_BURST_EN: auto-increment address and continue while csN stays low.
module spi_transaction_fsm #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              csN,
  input  logic              sclkPosEdge,
  input  logic              sclkNegEdge,
  input  logic [ADDR_W:0]   shiftIn,
  output logic              shiftEn,
  output logic              srLoad,
  output logic              memWriteEnable,
  output logic              misoEnable,
  output logic [ADDR_W-1:0] addr
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    DECODE,
    READ_LOAD,
    READ_SHIFT,
    WRITE_SHIFT,
    WRITE_COMMIT,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_bitCount;
  logic [2:0]        w_bitCount;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_bitCount <= '0;
      r_addr     <= '0;
    end else begin
      r_state    <= w_next;
      r_bitCount <= w_bitCount;
      r_addr     <= w_addr;
    end
  end

  assign addr = r_addr;

  always_comb begin
    w_next         = r_state;
    w_bitCount     = r_bitCount;
    w_addr         = r_addr;
    shiftEn        = 1'b0;
    srLoad         = 1'b0;
    memWriteEnable = 1'b0;
    misoEnable     = 1'b0;

    case (r_state)
      IDLE: begin
        if (!csN) begin
          w_next     = GET_ADDR;
          w_bitCount = '0;
        end
      end
      GET_ADDR, WRITE_SHIFT: begin
        shiftEn = sclkPosEdge;
        if (sclkPosEdge) begin
          w_bitCount = r_bitCount + 3'd1;
          if (r_bitCount == 3'd7)
            w_next = (r_state == GET_ADDR) ? DECODE : WRITE_COMMIT;
        end
      end
      DECODE: begin
        w_addr     = shiftIn[ADDR_W:1];
        w_bitCount = '0;
        w_next     = shiftIn[0] ? READ_LOAD : WRITE_SHIFT;
      end
      READ_LOAD: begin
        misoEnable = 1'b1;
        srLoad     = !csN;
        w_next     = READ_SHIFT;
      end
      READ_SHIFT: begin
        misoEnable = 1'b1;
        shiftEn    = sclkNegEdge;
        if (sclkNegEdge) begin
          w_bitCount = r_bitCount + 3'd1;
          if (r_bitCount == 3'd7) begin
`ifdef SPI_FSM_BURST_EN
            w_addr     = r_addr + 1'b1;
            w_bitCount = '0;
            w_next     = READ_LOAD;
`else
            w_next     = DONE;
`endif
          end
        end
      end
      WRITE_COMMIT: begin
        memWriteEnable = !csN;
`ifdef SPI_FSM_BURST_EN
        w_addr     = r_addr + 1'b1;
        w_bitCount = '0;
        w_next     = WRITE_SHIFT;
`else
        w_next     = DONE;
`endif
      end
      DONE: begin
      end
      default: w_next = IDLE;
    endcase

    // Deselect overrides every transition, including one coinciding with the 8th edge.
    if (csN && (r_state != IDLE)) begin
      w_next     = IDLE;
      w_bitCount = r_bitCount;
      w_addr     = r_addr;
    end
  end

endmodule
